demux_onehot_1to4: RTL

DEMUX_ONEHOT_1TO4 -- requirements
Module: demux_onehot_1to4

---
 rtl/demux_onehot_1to4.sv | 104 ++++++++++
 1 files changed

// File: rtl/demux_onehot_1to4.sv
// One-hot 1-to-4 demultiplexer with a single-entry register per output lane.
// Illegal selects (zero-hot or multi-hot) are accepted and discarded; each
// discard raises a sticky error flag and bumps a saturating drop counter.
module demux_onehot_1to4 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_in,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [3:0]       io_sel,
    output logic [WIDTH-1:0] io_out0,
    output logic [WIDTH-1:0] io_out1,
    output logic [WIDTH-1:0] io_out2,
    output logic [WIDTH-1:0] io_out3,
    output logic [3:0]       io_out_valid,
    input  logic [3:0]       io_out_ready,
    input  logic             io_err_clr,
    output logic             io_err,
    output logic [CNT_W-1:0] io_drop_cnt
);

    logic [WIDTH-1:0] data_q [4];
    logic [3:0]       valid_q;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             sel_legal;
    logic [3:0]       lane_free;
    logic [3:0]       load;
    logic [3:0]       drain;
    logic             drop;

    // Decode the select and work out which lanes can accept a word this cycle.
    always_comb begin
        sel_legal = (io_sel != 4'b0000) && ((io_sel & (io_sel - 4'd1)) == 4'b0000);
        lane_free = ~valid_q | io_out_ready;
        // Illegal selects are always swallowed, so ready never depends on io_in_valid.
        io_in_ready = sel_legal ? |(io_sel & lane_free) : 1'b1;
        load  = (io_in_valid && io_in_ready && sel_legal) ? io_sel : 4'b0000;
        drain = valid_q & io_out_ready;
        drop  = io_in_valid && !sel_legal;
    end

    // Next state of the error flag and drop counter; a drop wins over a clear.
    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (drop) begin
            err_d = 1'b1;
            cnt_d = io_err_clr ? '0 : cnt_q;
            if (cnt_d != {CNT_W{1'b1}}) begin
                cnt_d = cnt_d + CNT_W'(1);
            end
        end else if (io_err_clr) begin
            err_d = 1'b0;
            cnt_d = '0;
        end
    end

    // Lane registers: a load takes precedence over a drain of the same lane.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_q[k]  <= io_in;
                    valid_q[k] <= 1'b1;
                end else if (drain[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    // Error flag and drop counter registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    // Registered outputs straight from state.
    always_comb begin
        io_out0      = data_q[0];
        io_out1      = data_q[1];
        io_out2      = data_q[2];
        io_out3      = data_q[3];
        io_out_valid = valid_q;
        io_err       = err_q;
        io_drop_cnt  = cnt_q;
    end

endmodule
